// File: rtl/uart_link.sv
// UART link: TX/RX FIFOs, 8N1-style framing with optional parity, sticky error flags.
// Optional feature: define UART_LINK_LOOPBACK_EN to add a loopback port feeding the TX line into the receiver.
module uart_link #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              tx_busy,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_busy,
  input  logic              err_clr,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
`ifdef UART_LINK_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic          PAR_ODD  = (PARITY == 1);
  localparam logic          HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW:0]       r_tx_wp, r_tx_rp;
  logic              w_tx_empty, w_tx_full, w_tx_wr, w_tx_pop;
  logic [DATA_W-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_tx_wr    = tx_valid && !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_tx_wr) r_tx_mem[r_tx_wp[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_wr)  r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  state_t            r_tx_state, w_tx_next;
  logic [CW-1:0]     r_tx_cnt;
  logic [BW-1:0]     r_tx_bit;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_par, w_tx_tick, w_tx_line;

  assign w_tx_tick = (r_tx_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    w_tx_line = 1'b1;
    case (r_tx_state)
      S_IDLE: if (!w_tx_empty) begin
        w_tx_pop  = 1'b1;
        w_tx_next = S_START;
      end
      S_START: begin
        w_tx_line = 1'b0;
        if (w_tx_tick) w_tx_next = S_DATA;
      end
      S_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_tick && r_tx_bit == BIT_LAST) w_tx_next = HAS_PAR ? S_PAR : S_STOP;
      end
      S_PAR: begin
        w_tx_line = r_tx_par;
        if (w_tx_tick) w_tx_next = S_STOP;
      end
      S_STOP: if (w_tx_tick) begin
        // Chain straight into the next frame when more data is waiting.
        if (!w_tx_empty) begin
          w_tx_pop  = 1'b1;
          w_tx_next = S_START;
        end else begin
          w_tx_next = S_IDLE;
        end
      end
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_cnt <= (r_tx_state == S_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_head;
        r_tx_par   <= (^w_tx_head) ^ PAR_ODD;
        r_tx_bit   <= '0;
      end else if (r_tx_state == S_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + 1'b1;
      end
    end
  end

  // ---------------- RX input select ----------------
  logic r_rxd_s1, r_rxd_s2, r_rx_prev, w_rx_in;

`ifdef UART_LINK_LOOPBACK_EN
  assign w_rx_in = loopback ? w_tx_line : r_rxd_s2;
  assign txd     = loopback ? 1'b1 : w_tx_line;
`else
  assign w_rx_in = r_rxd_s2;
  assign txd     = w_tx_line;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_s1  <= 1'b1;
      r_rxd_s2  <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rxd_s1  <= rxd;
      r_rxd_s2  <= r_rxd_s1;
      r_rx_prev <= w_rx_in;
    end
  end

  // ---------------- RX FSM ----------------
  state_t            r_rx_state, w_rx_next;
  logic [CW-1:0]     r_rx_cnt;
  logic [BW-1:0]     r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift;
  logic              r_rx_par_bad;
  logic              w_rx_adv, w_rx_push, w_rx_set_par, w_rx_set_frm;

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_rx_push    = 1'b0;
    w_rx_set_par = 1'b0;
    w_rx_set_frm = 1'b0;
    // START samples mid-bit; every later bit is one full bit period after the previous sample.
    w_rx_adv     = (r_rx_state == S_START) ? (r_rx_cnt == DIV_HALF) : (r_rx_cnt == DIV_LAST);
    case (r_rx_state)
      S_IDLE:  if (r_rx_prev && !w_rx_in) w_rx_next = S_START;
      S_START: if (w_rx_adv) w_rx_next = w_rx_in ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_adv && r_rx_bit == BIT_LAST) w_rx_next = HAS_PAR ? S_PAR : S_STOP;
      S_PAR:   if (w_rx_adv) w_rx_next = S_STOP;
      S_STOP:  if (w_rx_adv) begin
        w_rx_next    = S_IDLE;
        w_rx_set_frm = !w_rx_in;
        w_rx_set_par = r_rx_par_bad;
        w_rx_push    = w_rx_in && !r_rx_par_bad;
      end
      default: w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bad <= 1'b0;
    end else begin
      r_rx_cnt <= (r_rx_state == S_IDLE || w_rx_adv) ? '0 : r_rx_cnt + 1'b1;
      if (r_rx_state == S_START && w_rx_adv) begin
        r_rx_bit     <= '0;
        r_rx_par_bad <= 1'b0;
      end
      if (r_rx_state == S_DATA && w_rx_adv) begin
        r_rx_shift <= {w_rx_in, r_rx_shift[DATA_W-1:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
      if (r_rx_state == S_PAR && w_rx_adv)
        r_rx_par_bad <= ((^r_rx_shift) ^ w_rx_in) != PAR_ODD;
    end
  end

  // ---------------- RX FIFO and flags ----------------
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]       r_rx_wp, r_rx_rp;
  logic              w_rx_empty, w_rx_full, w_rx_pop, w_rx_wr, w_rx_ovr;
  logic              r_parity_err, r_frame_err, r_overrun;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_rx_pop   = rx_ready && !w_rx_empty;
  assign w_rx_wr    = w_rx_push && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr   = w_rx_push && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wp      <= '0;
      r_rx_rp      <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_rx_wr)  r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      // A new error wins over a coincident clear.
      r_parity_err <= (r_parity_err && !err_clr) || w_rx_set_par;
      r_frame_err  <= (r_frame_err  && !err_clr) || w_rx_set_frm;
      r_overrun    <= (r_overrun    && !err_clr) || w_rx_ovr;
    end
  end

  assign tx_ready   = !w_tx_full;
  assign tx_busy    = (r_tx_state != S_IDLE);
  assign rx_data    = r_rx_mem[r_rx_rp[AW-1:0]];
  assign rx_valid   = !w_rx_empty;
  assign rx_busy    = (r_rx_state != S_IDLE);
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: doc/uart_link.md
UART_LINK -- requirements
Module: uart_link

Interface
REQ-001 Parameter CLK_DIV, default 434, clocks per UART bit; legal range 4 or greater.
REQ-002 Parameter DATA_W, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO; power of two, 2 or greater.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port rst  in  1  synchronous reset, active-high.
REQ-007 Port tx_data  in  DATA_W  byte to transmit.
REQ-008 Port tx_valid  in  1  write request for tx_data.
REQ-009 Port tx_ready  out  1  TX FIFO not full.
REQ-010 Port txd  out  1  serial output, idle high.
REQ-011 Port tx_busy  out  1  TX FSM not IDLE.
REQ-012 Port rxd  in  1  asynchronous serial input.
REQ-013 Port rx_data  out  DATA_W  RX FIFO head, first-word fall-through.
REQ-014 Port rx_valid  out  1  RX FIFO not empty.
REQ-015 Port rx_ready  in  1  pops the RX head when rx_valid is high.
REQ-016 Port rx_busy  out  1  RX FSM not IDLE.
REQ-017 Port err_clr  in  1  clears all sticky error flags.
REQ-018 Port parity_err, frame_err, overrun  out  1 each  sticky error flags.

Function
REQ-019 TX FIFO write SHALL occur on a cycle with tx_valid && tx_ready; a write attempted while full is ignored.
REQ-020 TX FSM states SHALL be IDLE, START, DATA, PAR, STOP; each bit lasts exactly CLK_DIV clocks.
REQ-021 In IDLE with the TX FIFO non-empty, the FSM SHALL pop the head and enter START on the same edge; txd goes low on the next cycle.
REQ-022 DATA SHALL shift out LSB first over DATA_W bits, then go to PAR (PARITY≠0) or STOP.
REQ-023 The PAR bit SHALL equal XOR of the data bits (even mode) or its inverse (odd mode).
REQ-024 STOP SHALL be one high bit; if the FIFO is non-empty at STOP end, the FSM SHALL go directly to START with no idle gap.
REQ-025 rxd SHALL pass through a 2-flop synchronizer before use.
REQ-026 RX FSM states SHALL be IDLE, START, DATA, PAR, STOP; a synchronized falling edge in IDLE enters START.
REQ-027 START SHALL sample at CLK_DIV/2; if the sample is high, the FSM returns to IDLE (glitch rejection) with no flag set.
REQ-028 Subsequent bits SHALL be sampled every CLK_DIV clocks from the START mid-sample.
REQ-029 A parity mismatch SHALL set parity_err; the byte SHALL be discarded.
REQ-030 A low STOP sample SHALL set frame_err; the byte SHALL be discarded.
REQ-031 A good byte SHALL be pushed at the STOP mid-sample; the RX FSM returns to IDLE on that same edge.
REQ-032 If the RX FIFO is full at push time and there is no simultaneous pop, the byte SHALL be dropped and overrun set.
REQ-033 A simultaneous pop and push on a full RX FIFO SHALL accept the push.
REQ-034 Error flags SHALL stay set until err_clr; if err_clr and a new error coincide, the flag SHALL end set.
REQ-035 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full and empty are decoded from the MSB difference.

Reset
REQ-036 While rst is high, both FIFOs SHALL empty, both FSMs go to IDLE, and txd=1, tx_ready=1, rx_valid=0, tx_busy=0, rx_busy=0, and all error flags 0.
REQ-037 Reset mid-frame SHALL abort the frame, with txd high on the cycle after rst is sampled; no partial byte is pushed.

Configuration
REQ-038 With UART_LINK_LOOPBACK_EN defined, an input port loopback (1 bit) SHALL exist; when it is 1, the receiver input is the internal TX serial line (no synchronizer delay required) and txd is held at 1.
REQ-039 Without UART_LINK_LOOPBACK_EN, the loopback port SHALL be absent and the receiver SHALL always use rxd.

Verification
REQ-040 With CLK_DIV=4, PARITY=2: write 0xA5 -> txd frame is 0,1,0,1,0,0,1,0,1,0(parity),1, each level lasting 4 clocks; tx_busy high for 44 clocks.
REQ-041 With CLK_DIV=4, PARITY=2: write 3 bytes back-to-back -> 3 contiguous frames, no idle between STOP and the next START, tx_ready never low.
REQ-042 Drive rxd with a 0x3C frame with a bad parity bit -> parity_err=1 and rx_valid stays 0; pulse err_clr -> parity_err=0.
REQ-043 Drive FIFO_DEPTH+1 good frames with rx_ready=0 -> rx_valid=1, overrun=1, and popping returns exactly FIFO_DEPTH bytes in order.
REQ-044 A 1-clock low glitch on rxd -> rx_busy pulses, then returns to IDLE; no push and no flags.
REQ-045 With UART_LINK_LOOPBACK_EN defined and loopback=1: write 0x5A -> rx_data=0x5A with rx_valid=1, and txd stays 1 throughout.
